// File: rtl/draw_cmd_sched_pkg.sv
// rtl/draw_cmd_sched_pkg.sv - shared widths, draw opcodes and scheduler state encodings
package draw_cmd_sched_pkg;

  localparam int OP_W      = 8;
  localparam int PAYLOAD_W = 256;
  localparam int ENTRY_W   = OP_W + PAYLOAD_W;

  typedef enum logic [OP_W-1:0] {
    DRAW_OP_NOP   = 8'h00,
    DRAW_OP_RECT  = 8'h01,
    DRAW_OP_LINE  = 8'h02,
    DRAW_OP_BLIT  = 8'h03,
    DRAW_OP_FENCE = 8'h80
  } draw_op_e;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [PAYLOAD_W-1:0] data;
  } draw_cmd_t;

  function automatic draw_cmd_t pack_cmd(input logic [OP_W-1:0] op,
                                         input logic [PAYLOAD_W-1:0] data);
    draw_cmd_t c;
    c.op   = op;
    c.data = data;
    return c;
  endfunction

endpackage

// File: rtl/draw_cmd_sched_if.sv
// rtl/draw_cmd_sched_if.sv - host command port, draw-unit handshake and status bundle
// irq/irq_clr exist only when DRAW_CMD_SCHED_IRQ_EN is defined.
interface draw_cmd_sched_if #(parameter int AW = 3);
  import draw_cmd_sched_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_W-1:0]      cmd_op;
  logic [PAYLOAD_W-1:0] cmd_data;
  logic                 flush;
  logic [OP_W-1:0]      du_command;
  logic [PAYLOAD_W-1:0] du_data;
  logic                 du_commit;
  logic                 du_ack;
  logic                 du_done;
  logic                 busy;
  logic [AW:0]          level;
  logic [15:0]          done_cnt;
  logic                 err;
`ifdef DRAW_CMD_SCHED_IRQ_EN
  logic                 irq;
  logic                 irq_clr;

  modport master (output cmd_valid, cmd_op, cmd_data, flush, du_ack, du_done, irq_clr,
                  input  cmd_ready, du_command, du_data, du_commit, busy, level, done_cnt, err, irq);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, flush, du_ack, du_done, irq_clr,
                  output cmd_ready, du_command, du_data, du_commit, busy, level, done_cnt, err, irq);
`else
  modport master (output cmd_valid, cmd_op, cmd_data, flush, du_ack, du_done,
                  input  cmd_ready, du_command, du_data, du_commit, busy, level, done_cnt, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, flush, du_ack, du_done,
                  output cmd_ready, du_command, du_data, du_commit, busy, level, done_cnt, err);
`endif

endinterface

// File: rtl/draw_cmd_fifo.sv
// rtl/draw_cmd_fifo.sv - synchronous command FIFO (opcode + payload) with flush
module draw_cmd_fifo
  import draw_cmd_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic               full_o,
  output logic [AW:0]        level_o,
  output logic [ENTRY_W-1:0] head_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        level_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  // Flush beats both push and pop in the same cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & (level_q != '0) & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/draw_cmd_sched.sv
// rtl/draw_cmd_sched.sv - queues host draw commands and issues them one at a time to the draw unit
// Optional DRAW_CMD_SCHED_IRQ_EN adds a sticky drain/error interrupt.
module draw_cmd_sched
  import draw_cmd_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1048575
) (
  input logic             clk,
  input logic             rst_n,
  draw_cmd_sched_if.slave bus
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_e         state_q;
  logic                 du_commit_q;
  logic [OP_W-1:0]      du_command_q;
  logic [PAYLOAD_W-1:0] du_data_q;
  logic [15:0]          done_cnt_q;
  logic                 err_q;
  logic [WDW-1:0]       wd_q;

  draw_cmd_t            wr_cmd;
  draw_cmd_t            head;
  logic                 full;
  logic [AW:0]          level;
  logic                 pop;
  logic                 step_done;
  logic                 wd_fire;
  logic                 timeout;

  assign wr_cmd = pack_cmd(bus.cmd_op, bus.cmd_data);

  draw_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.cmd_valid),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .wdata_i (wr_cmd),
    .full_o  (full),
    .level_o (level),
    .head_o  (head)
  );

  assign pop       = (state_q == SCHED_IDLE) && (level != '0) && !bus.flush;
  assign step_done = ((state_q == SCHED_ISSUE) && bus.du_ack) ||
                     ((state_q == SCHED_WAIT) && bus.du_done);
  assign wd_fire   = (TIMEOUT != 0) && (state_q != SCHED_IDLE) && (wd_q == WDW'(TIMEOUT - 1));
  // A handshake landing on the last watchdog cycle still counts as progress.
  assign timeout   = wd_fire && !step_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SCHED_IDLE;
      du_commit_q  <= 1'b0;
      du_command_q <= '0;
      du_data_q    <= '0;
      done_cnt_q   <= '0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      case (state_q)
        SCHED_IDLE: begin
          wd_q <= '0;
          if (pop) begin
            du_command_q <= head.op;
            du_data_q    <= head.data;
            du_commit_q  <= 1'b1;
            state_q      <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          if (step_done) begin
            du_commit_q <= 1'b0;
            state_q     <= SCHED_WAIT;
            wd_q        <= '0;
          end else if (timeout) begin
            err_q       <= 1'b1;
            du_commit_q <= 1'b0;
            state_q     <= SCHED_IDLE;
            wd_q        <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        SCHED_WAIT: begin
          if (step_done) begin
            done_cnt_q <= done_cnt_q + 16'd1;
            state_q    <= SCHED_IDLE;
            wd_q       <= '0;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= SCHED_IDLE;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = ~full | bus.flush;
  assign bus.du_commit  = du_commit_q;
  assign bus.du_command = du_command_q;
  assign bus.du_data    = du_data_q;
  assign bus.done_cnt   = done_cnt_q;
  assign bus.err        = err_q;
  assign bus.level      = level;
  assign bus.busy       = (level != '0) || (state_q != SCHED_IDLE);

`ifdef DRAW_CMD_SCHED_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if ((step_done && (state_q == SCHED_WAIT) && (level == '0)) || (timeout && !err_q)) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_draw_cmd_sched.sv
// tb/tb_draw_cmd_sched.sv - self-checking bench: command vector table, multi-cycle sequences, issue scoreboard
module tb_draw_cmd_sched;
  import draw_cmd_sched_pkg::*;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0]   op;
    logic [255:0] data;
    int           ack_l;
    int           done_l;
    logic [15:0]  exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  draw_cmd_sched_if #(.AW(AW)) bus ();

  draw_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int        checks = 0;
  int        errors = 0;
  draw_cmd_t exp_q[$];
  int        ack_lat = 0;
  int        done_lat = 0;
  logic      du_stall = 1'b0;

  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Draw-unit model plus scoreboard: every new du_commit must match the oldest accepted command.
  initial begin : du_model
    logic      prev_commit;
    logic      waiting;
    int        ack_cnt;
    int        done_wait;
    draw_cmd_t cur;
    prev_commit = 1'b0;
    waiting     = 1'b0;
    ack_cnt     = 0;
    done_wait   = 0;
    cur         = '0;
    bus.du_ack  = 1'b0;
    bus.du_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.du_ack  = 1'b0;
      bus.du_done = 1'b0;
      if (!rst_n) begin
        prev_commit = 1'b0;
        waiting     = 1'b0;
      end else begin
        if (bus.du_commit && !prev_commit) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got op %0h expected no issue", bus.du_command);
          end else begin
            cur = exp_q.pop_front();
            chk("issue_op", bus.du_command, cur.op);
            chk("issue_data", bus.du_data, cur.data);
          end
          ack_cnt = ack_lat;
        end
        if (waiting) begin
          if (done_wait == 0) begin
            bus.du_done = 1'b1;
            waiting     = 1'b0;
          end else begin
            done_wait--;
          end
        end else if (bus.du_commit && !du_stall) begin
          if (ack_cnt == 0) begin
            chk("ack_op_stable", bus.du_command, cur.op);
            bus.du_ack = 1'b1;
            waiting    = 1'b1;
            done_wait  = done_lat;
          end else begin
            ack_cnt--;
          end
        end
        prev_commit = bus.du_commit;
      end
    end
  end

  task automatic push(input logic [7:0] op, input logic [255:0] data, input bit accept);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    if (accept) exp_q.push_back(pack_cmd(op, data));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bus.busy || bus.du_commit) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_in_time"}, n < budget, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_du_commit"}, bus.du_commit, 1'b0);
    chk({tag, "_du_command"}, bus.du_command, 8'h00);
    chk({tag, "_du_data"}, bus.du_data, 256'h0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_level"}, bus.level, 4'd0);
    chk({tag, "_done_cnt"}, bus.done_cnt, 16'd0);
    chk({tag, "_err"}, bus.err, 1'b0);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[4];
    int   exp_done;
    int   lvl;
    int   n;

    vecs[0] = '{8'h01, 256'h00F8000A00A001400A, 0, 0, 16'd1};
    vecs[1] = '{8'h02, {8{32'hDEADBEEF}}, 3, 5, 16'd2};
    vecs[2] = '{8'h03, {256{1'b1}}, 1, 10, 16'd3};
    vecs[3] = '{8'h80, {32{8'hA5}}, 5, 2, 16'd4};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.flush     = 1'b0;
`ifdef DRAW_CMD_SCHED_IRQ_EN
    bus.irq_clr   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ack_lat  = vecs[i].ack_l;
      done_lat = vecs[i].done_l;
      push(vecs[i].op, vecs[i].data, 1'b1);
      chk($sformatf("v%0d_commit_n1", i), bus.du_commit, 1'b0);
      chk($sformatf("v%0d_busy_n1", i), bus.busy, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_commit_n2", i), bus.du_commit, 1'b1);
      wait_idle($sformatf("v%0d", i), 60);
      chk($sformatf("v%0d_done_cnt", i), bus.done_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d_level", i), bus.level, 4'd0);
      chk($sformatf("v%0d_err", i), bus.err, 1'b0);
    end
    exp_done = 4;

    // Burst: one command held in ISSUE, then nine pushes against an eight-deep queue.
    du_stall = 1'b1;
    ack_lat  = 0;
    done_lat = 0;
    push(8'h10, 256'h10, 1'b1);
    @(negedge clk);
    chk("burst_head_commit", bus.du_commit, 1'b1);
    lvl = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("burst_ready_%0d", k), bus.cmd_ready, lvl != DEPTH);
      push(8'(8'h20 + k), {8{24'hB0B0B0, 8'(k)}}, lvl < DEPTH);
      if (lvl < DEPTH) lvl++;
    end
    chk("burst_level_full", bus.level, 4'd8);
    chk("burst_ready_low", bus.cmd_ready, 1'b0);
    chk("burst_commit_held", bus.du_commit, 1'b1);
    du_stall = 1'b0;
    wait_idle("burst", 200);
    exp_done += 9;
    chk("burst_done_cnt", bus.done_cnt, 16'(exp_done));

    // Push and pop on the same edge at level 1 in IDLE.
    push(8'h31, {8{32'h31313131}}, 1'b1);
    chk("pp_level_before", bus.level, 4'd1);
    push(8'h32, {8{32'h32323232}}, 1'b1);
    chk("pp_level_same", bus.level, 4'd1);
    chk("pp_commit", bus.du_commit, 1'b1);
    chk("pp_older_op", bus.du_command, 8'h31);
    wait_idle("pp", 60);
    exp_done += 2;
    chk("pp_done_cnt", bus.done_cnt, 16'(exp_done));

    // Flush with five queued while one command sits in WAIT_DONE; a same-cycle push is dropped.
    ack_lat  = 0;
    done_lat = 10;
    push(8'h40, {8{32'h40404040}}, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) push(8'(8'h41 + k), 256'(k), 1'b1);
    chk("fl_level5", bus.level, 4'd5);
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 8'h4F;
    bus.cmd_data  = 256'h4F;
    chk("fl_ready_with_flush", bus.cmd_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("fl_level0", bus.level, 4'd0);
    chk("fl_busy_inflight", bus.busy, 1'b1);
    wait_idle("fl", 60);
    exp_done += 1;
    chk("fl_done_cnt", bus.done_cnt, 16'(exp_done));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("fl_no_reissue_%0d", k), bus.du_commit, 1'b0);
    end

    // Watchdog: the draw unit never acks the first command.
    du_stall = 1'b1;
    done_lat = 0;
    push(8'h50, 256'h50, 1'b1);
    push(8'h51, 256'h51, 1'b1);
    n = 0;
    while (bus.du_commit && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("wd_commit_cycles", n, TIMEOUT);
    chk("wd_err", bus.err, 1'b1);
    chk("wd_commit_dropped", bus.du_commit, 1'b0);
    chk("wd_level", bus.level, 4'd1);
    chk("wd_done_unchanged", bus.done_cnt, 16'(exp_done));
    du_stall = 1'b0;
    @(negedge clk);
    chk("wd_next_issue", bus.du_commit, 1'b1);
    wait_idle("wd", 60);
    exp_done += 1;
    chk("wd_done_cnt", bus.done_cnt, 16'(exp_done));
    chk("wd_err_sticky", bus.err, 1'b1);

    // Asynchronous reset while a command is in WAIT_DONE.
    done_lat = 12;
    push(8'h60, 256'h60, 1'b1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_lat = 0;
    push(8'h61, 256'h61, 1'b1);
    chk("post_rst_commit_n1", bus.du_commit, 1'b0);
    @(negedge clk);
    chk("post_rst_commit_n2", bus.du_commit, 1'b1);
    wait_idle("post_rst", 60);
    chk("post_rst_done_cnt", bus.done_cnt, 16'd1);
    chk("post_rst_err", bus.err, 1'b0);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
